control_pulsadores_f_i: RTL
===========================

Name: control_pulsadores_f_i

Overview:
- Front-panel input block for the PWM system: debounces three raw pushbuttons (up, down, mode).
- Maintains the Corriente (5-bit) and Frecuencia (3-bit) setpoints and the selector_F_I flag.
- These are the same values the display controller decodes and shows, so this block is the writer and the display path is the reader.
- Supports press-and-hold auto-repeat on up/down.

Parameters:
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); must be >=2.
- REP_DELAY, 25000000, cycles up/down must stay held after the accepted press before the first auto-repeat step.
- REP_PERIOD, 5000000, cycles between subsequent auto-repeat steps.
- I_MAX, 31, saturation ceiling for Corriente.
- F_MAX, 7, saturation ceiling for Frecuencia.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- btn_up  input  1  raw up button, active-high, asynchronous to clk.
- btn_down  input  1  raw down button, active-high, asynchronous.
- btn_mode  input  1  raw mode button, active-high, asynchronous.
- Corriente  output  5  current setpoint, registered.
- Frecuencia  output  3  frequency setpoint, registered.
- selector_F_I  output  1  0 = up/down adjust Corriente, 1 = up/down adjust Frecuencia; registered.
- cambio  output  1  one-cycle pulse in the cycle after any setpoint or selector update.

Behaviour:
- Reset (rst=0, asynchronous): Corriente=0, Frecuencia=0, selector_F_I=0, cambio=0; all synchronizer, debounce, stable and repeat state cleared to 0 / IDLE. Reset mid-hold cancels repeat; after release of reset a still-held button must re-debounce from zero.
- Synchronizer: 2-FF per button (s1, s2). Raw level first sampled at edge k appears on s2 at edge k+1.
- Debounce, per button: counter increments each cycle s2 != stable and clears on any cycle s2 == stable. When s2 != stable with counter == DEB_CYCLES-1, stable <= s2 and the counter clears. Glitches shorter than DEB_CYCLES cycles never change stable.
- Press event: stable rising edge (stable=1, stable_prev=0) gives a one-cycle press pulse. Releases produce no event.
- Latency: raw high from edge k onward gives stable=1 at edge k+1+DEB_CYCLES; the setpoint updates at edge k+2+DEB_CYCLES; cambio is high during the cycle following that edge.
- Auto-repeat FSM, separate for up and down; mode has no repeat.
  - IDLE: on press pulse, issue one step, go to DELAY, load timer=0.
  - DELAY: timer counts while stable=1. At timer==REP_DELAY-1: step, timer=0, go to REPEAT.
  - REPEAT: at timer==REP_PERIOD-1: step, timer=0.
  - Any state: stable=0 -> IDLE, timer=0.
- Step application, in the same cycle as the step pulse:
  - Target is selected by selector_F_I as registered before this cycle.
  - Up step: target = min(target+1, MAX).
  - Down step: target = max(target-1, 0).
  - Up and down steps in the same cycle cancel; no change and no cambio.
  - Saturated steps (up at MAX, down at 0) leave the value unchanged and do not assert cambio.
- Mode press pulse: selector_F_I toggles and cambio asserts. If a mode press and a step coincide, the step applies to the pre-toggle selection and the toggle also takes effect; cambio asserts once.
- Width rules: no wrap-around in either direction. I_MAX must be <=31 and F_MAX <=7. The non-selected setpoint never changes.
- Outputs are glitch-free registers. cambio is a registered copy of "an update occurred".

Test Plan (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8, I_MAX=31, F_MAX=7):
1. Reset: rst=0 with all buttons high -> all outputs 0. Release rst, hold btn_up -> Corriente=1 exactly 6 edges after first sampled-high edge; cambio high 1 cycle.
2. Bounce: btn_up pulses 3 cycles high, 2 low, 3 high, then low -> Corriente unchanged, cambio never asserted.
3. Auto-repeat: hold btn_up 60 cycles after acceptance -> Corriente steps at accept, +20, +28, +36, +44, +52 (value 6). Release -> no further steps.
4. Saturation: selector_F_I=1, Frecuencia=7, press up -> stays 7, cambio=0. Set Frecuencia=0, press down -> stays 0. Corriente untouched throughout.
5. Mode and simultaneity: press mode -> selector_F_I 0->1 with cambio. Up and down accepted in the same cycle -> no change. Mode and up in the same cycle with selector=0, Corriente=4 -> Corriente=5, selector=1, single cambio.
6. Reset mid-repeat: hold btn_down in REPEAT, assert rst for 3 cycles while still holding -> outputs 0. After release of rst, first step occurs only after a full re-debounce (6 edges); Corriente stays 0 (saturated).

Source files
------------

// File: rtl/control_pulsadores_f_i.sv
// Front-panel buttons: 2-FF sync, debounce, up/down auto-repeat,
// saturating Corriente/Frecuencia setpoints and F/I selector.
module control_pulsadores_f_i #(
  parameter int DEB_CYCLES = 500000,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_PERIOD = 5000000,
  parameter int I_MAX      = 31,
  parameter int F_MAX      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_mode,
  output logic [4:0] Corriente,
  output logic [2:0] Frecuencia,
  output logic       selector_F_I,
  output logic       cambio
);

  localparam int DW  = $clog2(DEB_CYCLES);
  localparam int RMX = (REP_DELAY > REP_PERIOD) ?
                       REP_DELAY : REP_PERIOD;
  localparam int TW  = (RMX > 1) ? $clog2(RMX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rep_e;

  logic [2:0] w_raw;
  logic [2:0] w_press;
  logic [1:0] w_stb;
  logic [1:0] w_step;

  assign w_raw = {btn_mode, btn_down, btn_up};

  // index 0 = up, 1 = down, 2 = mode
  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic          r_s1;
    logic          r_s2;
    logic          r_stb;
    logic          r_stb_q;
    logic [DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1    <= 1'b0;
        r_s2    <= 1'b0;
        r_stb   <= 1'b0;
        r_stb_q <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_s1    <= w_raw[g];
        r_s2    <= r_s1;
        r_stb_q <= r_stb;
        if (r_s2 == r_stb) begin
          r_cnt <= '0;
        end else if (r_cnt == DW'(DEB_CYCLES - 1)) begin
          r_stb <= r_s2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
    end

    assign w_press[g] = r_stb & ~r_stb_q;

    if (g < 2) begin : g_lvl
      assign w_stb[g] = r_stb;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_rep
    rep_e          r_st;
    rep_e          w_st_nxt;
    logic [TW-1:0] r_tmr;
    logic [TW-1:0] w_tmr_nxt;
    logic          w_dly_end;
    logic          w_per_end;
    logic          w_stp;

    assign w_dly_end = (r_tmr == TW'(REP_DELAY - 1));
    assign w_per_end = (r_tmr == TW'(REP_PERIOD - 1));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_st  <= IDLE;
        r_tmr <= '0;
      end else begin
        r_st  <= w_st_nxt;
        r_tmr <= w_tmr_nxt;
      end
    end

    always_comb begin
      w_st_nxt  = r_st;
      w_tmr_nxt = '0;
      if (!w_stb[g]) begin
        w_st_nxt = IDLE;
      end else begin
        unique case (r_st)
          IDLE: begin
            if (w_press[g]) w_st_nxt = DELAY;
          end
          DELAY: begin
            if (w_dly_end) w_st_nxt = REPEAT;
            else w_tmr_nxt = r_tmr + TW'(1);
          end
          REPEAT: begin
            if (!w_per_end) w_tmr_nxt = r_tmr + TW'(1);
          end
          default: w_st_nxt = IDLE;
        endcase
      end
    end

    always_comb begin
      w_stp = 1'b0;
      if (w_stb[g]) begin
        unique case (r_st)
          IDLE:    w_stp = w_press[g];
          DELAY:   w_stp = w_dly_end;
          REPEAT:  w_stp = w_per_end;
          default: w_stp = 1'b0;
        endcase
      end
    end

    assign w_step[g] = w_stp;
  end

  logic       w_up;
  logic       w_dn;
  logic       w_upd;
  logic       w_sel_nxt;
  logic [4:0] w_cor_nxt;
  logic [2:0] w_frq_nxt;

  // coincident up/down steps cancel each other
  always_comb begin
    w_up      = w_step[0] & ~w_step[1];
    w_dn      = w_step[1] & ~w_step[0];
    w_cor_nxt = Corriente;
    w_frq_nxt = Frecuencia;
    w_sel_nxt = selector_F_I;
    w_upd     = 1'b0;
    unique case (1'b1)
      (w_up && !selector_F_I &&
       Corriente < 5'(I_MAX)): begin
        w_cor_nxt = Corriente + 5'd1;
        w_upd     = 1'b1;
      end
      (w_dn && !selector_F_I &&
       Corriente != 5'd0): begin
        w_cor_nxt = Corriente - 5'd1;
        w_upd     = 1'b1;
      end
      (w_up && selector_F_I &&
       Frecuencia < 3'(F_MAX)): begin
        w_frq_nxt = Frecuencia + 3'd1;
        w_upd     = 1'b1;
      end
      (w_dn && selector_F_I &&
       Frecuencia != 3'd0): begin
        w_frq_nxt = Frecuencia - 3'd1;
        w_upd     = 1'b1;
      end
      default: ;
    endcase
    if (w_press[2]) begin
      w_sel_nxt = ~selector_F_I;
      w_upd     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Corriente    <= '0;
      Frecuencia   <= '0;
      selector_F_I <= 1'b0;
      cambio       <= 1'b0;
    end else begin
      Corriente    <= w_cor_nxt;
      Frecuencia   <= w_frq_nxt;
      selector_F_I <= w_sel_nxt;
      cambio       <= w_upd;
    end
  end

endmodule
